ray_sweep_controller: RTL

Frame-level initiator that drives the horizontal wall-intersection finder once per screen column. On a frame request it computes the leftmost ray angle from the player heading. It issues one calculation per column, stepping the angle each time. It waits for the finder's completion, then hands each column's result to the column renderer over a valid/ready handshake. It sits between the player-state registers and the renderer, on the requesting side of the finder's `begin_calc`/`end_calc` protocol.

---
 rtl/ray_sweep_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ray_sweep_controller.sv
// Frame-level ray sweep: steps the ray angle across NUM_COLS columns, drives the wall finder
// and hands each result to the renderer. Optional watchdog in WAIT: define RAY_TIMEOUT_EN.
module ray_sweep_controller #(
   parameter int NUM_COLS       = 160,
   parameter int HALF_FOV       = 30,
   parameter int STEP_FRAC      = 192,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start_frame,
   input  logic signed [9:0]  player_angle_X,
   input  logic signed [9:0]  player_angle_Y,
   output logic signed [9:0]  alpha_X,
   output logic signed [9:0]  alpha_Y,
   output logic               begin_calc,
   input  logic               end_calc,
   input  logic               wall_found,
   input  logic signed [12:0] wallX,
   input  logic signed [12:0] wallY,
   output logic               col_valid,
   input  logic               col_ready,
   output logic [7:0]         col_index,
   output logic signed [12:0] col_wallX,
   output logic signed [12:0] col_wallY,
   output logic               col_hit,
   output logic               col_timeout,
   output logic               busy,
   output logic               frame_done
);

   if (NUM_COLS < 1 || NUM_COLS > 256 || STEP_FRAC < 0 || STEP_FRAC >= 512 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("ray_sweep_controller: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_EMIT  = 3'd3,
      S_NEXT  = 3'd4
   } state_t;

   state_t     state, state_nx;
   logic [7:0] idx;
   logic       last_col;
   logic       timeout_hit;

   assign col_index = idx;
   assign last_col  = (idx == 8'(NUM_COLS - 1));

`ifdef RAY_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd;

   // wd holds the number of WAIT cycles already spent on this column
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         wd <= '0;
      else if (state == S_ISSUE)
         wd <= '0;
      else if (state == S_WAIT && !timeout_hit)
         wd <= wd + 1'b1;
   end

   assign timeout_hit = (state == S_WAIT) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      begin_calc = 1'b0;
      col_valid  = 1'b0;
      frame_done = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE:  if (start_frame) state_nx = S_ISSUE;
         S_ISSUE: begin
            begin_calc = 1'b1;
            state_nx   = S_WAIT;
         end
         S_WAIT:  if (end_calc || timeout_hit) state_nx = S_EMIT;
         S_EMIT: begin
            col_valid = 1'b1;
            if (col_ready) state_nx = S_NEXT;
         end
         S_NEXT: begin
            frame_done = last_col;
            state_nx   = last_col ? S_IDLE : S_ISSUE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Start angle: heading + HALF_FOV, integer part folded back into 0..359
   logic signed [10:0] start_sum, start_int;
   assign start_sum = {player_angle_X[9], player_angle_X} + 11'(HALF_FOV);
   assign start_int = (start_sum >= 11'sd360) ? start_sum - 11'sd360 : start_sum;

   // Step: borrow out of the 1/512 fraction decrements the integer degrees
   logic signed [10:0] frac_dif, int_dec;
   logic               borrow;
   logic signed [9:0]  frac_nx, int_nx;
   assign frac_dif = {1'b0, alpha_Y} - 11'(STEP_FRAC);
   assign borrow   = frac_dif[10];
   assign frac_nx  = borrow ? 10'(frac_dif + 11'sd512) : frac_dif[9:0];
   assign int_dec  = {alpha_X[9], alpha_X} - 11'(borrow);
   assign int_nx   = (int_dec < 11'sd0) ? 10'sd359 : int_dec[9:0];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         alpha_X     <= '0;
         alpha_Y     <= '0;
         idx         <= '0;
         col_wallX   <= '0;
         col_wallY   <= '0;
         col_hit     <= 1'b0;
         col_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start_frame) begin
               alpha_X <= start_int[9:0];
               alpha_Y <= player_angle_Y;
               idx     <= '0;
            end
            S_WAIT: if (end_calc) begin
               col_wallX   <= wallX;
               col_wallY   <= wallY;
               col_hit     <= wall_found;
               col_timeout <= 1'b0;
            end else if (timeout_hit) begin
               col_wallX   <= '0;
               col_wallY   <= '0;
               col_hit     <= 1'b0;
               col_timeout <= 1'b1;
            end
            S_NEXT: if (!last_col) begin
               idx     <= idx + 8'd1;
               alpha_X <= int_nx;
               alpha_Y <= frac_nx;
            end
            default: ;
         endcase
      end
   end

endmodule
